alu_div_seq: RTL and testbench

Parametrised, multi-cycle signed/unsigned integer divider for the CPU datapath ALU. It replaces the single-cycle combinational divider with a one-bit-per-clock restoring divider behind a start/done handshake. It adds a selectable signed mode, a correctly signed remainder, and divide-by-zero detection. The control unit stalls on `busy` and latches results on `done`.

---
 rtl/alu_div_seq.sv | 142 ++++++++++++++
 tb/tb_alu_div_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider (one quotient bit per clock) with signed mode,
// dividend-signed remainder and divide-by-zero detection behind a start/done handshake.
module alu_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic             dvd_neg;
  logic             dsr_neg;
  logic             dsr_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH+1:0] acc_sh;
  logic [WIDTH+1:0] trial;
  logic             take;

  logic             busy_nx;
  logic             done_nx;
  logic             load_res;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  // Operand magnitude/sign extraction at the start handshake
  always_comb begin
    dvd_neg  = signed_mode & dividend[WIDTH-1];
    dsr_neg  = signed_mode & divisor[WIDTH-1];
    dsr_zero = (divisor == '0);
    dvd_mag  = dvd_neg ? WIDTH'(-dividend) : dividend;
    dsr_mag  = dsr_neg ? WIDTH'(-divisor) : divisor;
  end

  // One restoring step: shift {acc, q} left, trial-subtract; the sign bit of trial decides
  always_comb begin
    acc_sh = {acc, q[WIDTH-1]};
    trial  = acc_sh - {2'b00, m};
    take   = ~trial[WIDTH+1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = dsr_zero ? S_FIX : S_CALC;
      S_CALC: if (cnt == CW'(1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = 1'b0;
    load_res = 1'b0;
    if (state == S_FIX) begin
      done_nx  = 1'b1;
      load_res = 1'b1;
    end
    if (dz) begin
      res_q = '1;
      res_r = q;
    end else begin
      res_q = q_neg ? WIDTH'(-q) : q;
      res_r = r_neg ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    end
  end

  // Datapath; on divide-by-zero q carries the raw dividend straight to FIX
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt   <= CW'(WIDTH);
        acc   <= '0;
        q     <= dsr_zero ? dividend : dvd_mag;
        m     <= dsr_mag;
        q_neg <= dvd_neg ^ dsr_neg;
        r_neg <= dvd_neg;
        dz    <= dsr_zero;
      end else if (state == S_CALC) begin
        cnt <= cnt - CW'(1);
        acc <= take ? trial[WIDTH:0] : acc_sh[WIDTH:0];
        q   <= {q[WIDTH-2:0], take};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (load_res) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: arithmetic reference model with latency tracking, per-cycle
// compare against the 32-bit instance, directed literal cases, and an 8-bit instance.
module tb_alu_div_seq;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        signed_mode;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  logic        start8;
  logic        signed_mode8;
  logic [7:0]  dividend8;
  logic [7:0]  divisor8;
  logic        busy8;
  logic        done8;
  logic [7:0]  quotient8;
  logic [7:0]  remainder8;
  logic        div_by_zero8;

  int tests = 0;
  int fails = 0;

  alu_div_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  alu_div_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .signed_mode(signed_mode8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // Reference arithmetic: truncating division, remainder takes the dividend's sign
  task automatic ref_div(input logic sm, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rq, output logic [31:0] rr, output logic rdz);
    longint sa, sb;
    if (b == 32'd0) begin
      rq = 32'hFFFF_FFFF; rr = a; rdz = 1'b1;
    end else if (sm) begin
      sa = $signed(a); sb = $signed(b);
      rq = 32'(sa / sb); rr = 32'(sa % sb); rdz = 1'b0;
    end else begin
      rq = a / b; rr = a % b; rdz = 1'b0;
    end
  endtask

  // Model: result appears WIDTH+1 edges after an accepted start (1 edge on divide-by-zero)
  int          m_left;
  logic [31:0] m_pq, m_pr, t_q, t_r;
  logic        m_pdz, t_dz;
  logic        exp_busy, exp_done, exp_dz;
  logic [31:0] exp_q, exp_r;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0; exp_busy <= 1'b0; exp_done <= 1'b0;
      exp_q <= '0; exp_r <= '0; exp_dz <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          ref_div(signed_mode, dividend, divisor, t_q, t_r, t_dz);
          m_pq <= t_q; m_pr <= t_r; m_pdz <= t_dz;
          m_left   <= (divisor == 32'd0) ? 1 : 33;
          exp_busy <= 1'b1;
        end
      end else if (m_left == 1) begin
        m_left <= 0; exp_busy <= 1'b0; exp_done <= 1'b1;
        exp_q <= m_pq; exp_r <= m_pr; exp_dz <= m_pdz;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("cyc_busy", 32'(busy), 32'(exp_busy));
      chk("cyc_done", 32'(done), 32'(exp_done));
      chk("cyc_quotient", quotient, exp_q);
      chk("cyc_remainder", remainder, exp_r);
      chk("cyc_div_by_zero", 32'(div_by_zero), 32'(exp_dz));
    end
  end

  // Issue one division from the current point; optional literal result check and mid-CALC start
  task automatic issue(input string nm, input logic sm, input logic [31:0] a, input logic [31:0] b,
                       input logic lit, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input int inject_at);
    int n, bc, elat;
    elat = (b == 32'd0) ? 1 : 33;
    signed_mode = sm; dividend = a; divisor = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_mode = 1'($urandom);
    n = 1; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (n == inject_at) begin
        start = 1'b1; dividend = 32'd999; divisor = 32'd3; signed_mode = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within %0d edges", nm, n);
    end
    chk({nm, "_latency"}, 32'(n - 1), 32'(elat));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(elat));
    if (lit) begin
      chk({nm, "_quotient"}, quotient, eq);
      chk({nm, "_remainder"}, remainder, er);
      chk({nm, "_div_by_zero"}, 32'(div_by_zero), 32'(edz));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rsm, saw_done;
    int          n8;
    reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; signed_mode8 = 1'b0; dividend8 = '0; divisor8 = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    issue("u_100_7",   1'b0, 32'd100,          32'd7,          1'b1, 32'd14,         32'd2,          1'b0, 0);
    issue("s_m100_7",  1'b1, 32'hFFFF_FF9C,    32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 0);
    issue("s_100_m7",  1'b1, 32'd100,          32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0, 0);
    issue("s_m100_m7", 1'b1, 32'hFFFF_FF9C,    32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 0);
    issue("u_m100_7",  1'b0, 32'hFFFF_FF9C,    32'd7,          1'b1, 32'h2492_4916,  32'd2,          1'b0, 0);
    issue("s_ovf",     1'b1, 32'h8000_0000,    32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 0);
    issue("u_0_5",     1'b0, 32'd0,            32'd5,          1'b1, 32'd0,          32'd0,          1'b0, 0);
    issue("u_max_1",   1'b0, 32'hFFFF_FFFF,    32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0,          1'b0, 0);
    @(negedge clock);
    issue("dbz",       1'b0, 32'd1234,         32'd0,          1'b1, 32'hFFFF_FFFF,  32'd1234,       1'b1, 0);
    issue("after_dbz", 1'b0, 32'd50,           32'd5,          1'b1, 32'd10,         32'd0,          1'b0, 0);
    @(negedge clock);
    issue("inject",    1'b0, 32'd1000,         32'd10,         1'b1, 32'd100,        32'd0,          1'b0, 10);
    @(negedge clock);
    issue("b2b_first", 1'b0, 32'd77,           32'd7,          1'b1, 32'd11,         32'd0,          1'b0, 0);
    issue("b2b_second",1'b0, 32'd81,           32'd9,          1'b1, 32'd9,          32'd0,          1'b0, 0);

    // Reset in the middle of a calculation
    @(negedge clock);
    signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);
    issue("post_rst", 1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, 0);

    // Randomized operations, mixed gaps and back-to-back starts
    for (int i = 0; i < 150; i++) begin
      rsm = 1'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: rb = 32'hFFFF_FFFF;
        3: rb = $urandom_range(1, 15);
        4: begin ra = 32'h8000_0000; rb = $urandom; end
        5: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) @(negedge clock);
      issue("rand", rsm, ra, rb, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    end

    // 8-bit instance
    @(negedge clock);
    signed_mode8 = 1'b0; dividend8 = 8'd200; divisor8 = 8'd3; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    n8 = 1;
    while (!done8 && n8 < 40) begin
      @(posedge clock); #1;
      n8++;
    end
    chk("w8_latency", 32'(n8 - 1), 32'd9);
    chk("w8_quotient", 32'(quotient8), 32'd66);
    chk("w8_remainder", 32'(remainder8), 32'd2);
    chk("w8_dbz", 32'(div_by_zero8), 32'd0);

    signed_mode8 = 1'b1; dividend8 = 8'h80; divisor8 = 8'hFF; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    n8 = 1;
    while (!done8 && n8 < 40) begin
      @(posedge clock); #1;
      n8++;
    end
    chk("w8_ovf_latency", 32'(n8 - 1), 32'd9);
    chk("w8_ovf_quotient", 32'(quotient8), 32'h80);
    chk("w8_ovf_remainder", 32'(remainder8), 32'd0);

    signed_mode8 = 1'b0; dividend8 = 8'd7; divisor8 = 8'd0; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    n8 = 1;
    while (!done8 && n8 < 40) begin
      @(posedge clock); #1;
      n8++;
    end
    chk("w8_dbz_latency", 32'(n8 - 1), 32'd1);
    chk("w8_dbz_quotient", 32'(quotient8), 32'hFF);
    chk("w8_dbz_remainder", 32'(remainder8), 32'd7);
    chk("w8_dbz_flag", 32'(div_by_zero8), 32'd1);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
